serial_transmitter: RTL

Serializes a 7-bit word onto a single-wire link. The frame format is:
- idle line high
- start bit (0)
- 7 data bits, LSB first
- one parity bit (even by default)
- stop bit (1)

Each bit period is CLKS_PER_BIT clocks; the default of 1 clock per bit matches the link's receiver. The block is the sending end of the link and sits between a parallel producer and that receiver.

---
 rtl/serial_transmitter_if.sv | 12 +
 rtl/serial_transmitter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_transmitter_if.sv
// Parallel-producer side of the serial transmitter: request, word and line status.
// The producer drives through master; the transmitter uses slave.
interface serial_transmitter_if;
   logic       start;
   logic [6:0] data_in;
   logic       serial_out;
   logic       busy;
   logic       done;

   modport master (output start, data_in, input serial_out, busy, done);
   modport slave  (input start, data_in, output serial_out, busy, done);
endinterface

// File: rtl/serial_transmitter.sv
// Single-wire frame transmitter: start bit, 7 data bits LSB first, parity, stop,
// then a forced idle gap. serial_out, busy and done are all registered.
module serial_transmitter #(
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_ODD   = 0,
   parameter int GAP_BITS     = 1
) (
   input logic                 clk,
   input logic                 rstn,
   serial_transmitter_if.slave bus
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [BW-1:0]   r_baud, w_baud_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic [GW-1:0]   r_gap, w_gap_nxt;
   logic [6:0]      r_shift, w_shift_nxt;
   logic            r_parity, w_parity_nxt;
   logic            r_serial, w_serial_nxt;
   logic            r_busy;
   logic            r_done, w_done_nxt;
   logic            w_baud_end;

   assign w_baud_end = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = w_baud_end ? '0 : r_baud + 1'b1;
      w_bit_nxt    = r_bit;
      w_gap_nxt    = r_gap;
      w_shift_nxt  = r_shift;
      w_parity_nxt = r_parity;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            if (bus.start) begin
               w_state_nxt  = START;
               w_shift_nxt  = bus.data_in;
               w_parity_nxt = (PARITY_ODD != 0) ? ~^bus.data_in : ^bus.data_in;
            end
         end
         START: if (w_baud_end) begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
         end
         DATA: if (w_baud_end) begin
            if (r_bit == 3'd6) begin
               w_state_nxt = PARITY;
            end else begin
               w_bit_nxt   = r_bit + 1'b1;
               w_shift_nxt = r_shift >> 1;
            end
         end
         PARITY: if (w_baud_end) w_state_nxt = STOP;
         STOP: if (w_baud_end) begin
            w_state_nxt = GAP;
            w_gap_nxt   = '0;
            w_done_nxt  = 1'b1;
         end
         GAP: if (w_baud_end) begin
            if (r_gap == GAP_LAST) w_state_nxt = IDLE;
            else                   w_gap_nxt   = r_gap + 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
            w_baud_nxt  = '0;
         end
      endcase

      // Line level is registered from the next state so it changes only on edges.
      case (w_state_nxt)
         START:   w_serial_nxt = 1'b0;
         DATA:    w_serial_nxt = w_shift_nxt[0];
         PARITY:  w_serial_nxt = w_parity_nxt;
         default: w_serial_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_gap    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_serial <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bit    <= w_bit_nxt;
         r_gap    <= w_gap_nxt;
         r_shift  <= w_shift_nxt;
         r_parity <= w_parity_nxt;
         r_serial <= w_serial_nxt;
         r_busy   <= (w_state_nxt != IDLE);
         r_done   <= w_done_nxt;
      end
   end

   assign bus.serial_out = r_serial;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
endmodule
